// File: rtl/cb_chan_param_ccff_pkg.sv
// Shared helpers and controller state type for the parametrised X-channel connection block.
// Optional feature macro used by this slice: CB_CHAN_READBACK_EN.
package cb_chan_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } cb_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // One extra code beyond the last mux input is reserved for "disconnected".
  function automatic int unsigned sel_width(input int unsigned mux_size);
    return clog2(mux_size + 1);
  endfunction

  function automatic int unsigned disc_sel(input int unsigned sel_w);
    return (32'd1 << sel_w) - 32'd1;
  endfunction

endpackage

// File: rtl/cb_chan_param_ccff_if.sv
// Configuration chain and channel/pin bus of cb_chan_param_ccff.
// rb_load exists only when CB_CHAN_READBACK_EN is defined.
interface cb_chan_param_ccff_if #(
  parameter int unsigned CHAN_W   = 9,
  parameter int unsigned NUM_IPIN = 11
);
  logic                ccff_head;
  logic                ccff_en;
  logic                ccff_commit;
  logic                ccff_tail;
  logic                cfg_done;
  logic                cfg_err;
  logic [CHAN_W-1:0]   chanx_left_in;
  logic [CHAN_W-1:0]   chanx_right_in;
  logic [CHAN_W-1:0]   chanx_left_out;
  logic [CHAN_W-1:0]   chanx_right_out;
  logic [NUM_IPIN-1:0] ipin_out;
`ifdef CB_CHAN_READBACK_EN
  logic                rb_load;
`endif

  modport master (
    output ccff_head, ccff_en, ccff_commit, chanx_left_in, chanx_right_in,
    input  ccff_tail, cfg_done, cfg_err, chanx_left_out, chanx_right_out, ipin_out
`ifdef CB_CHAN_READBACK_EN
    , output rb_load
`endif
  );

  modport slave (
    input  ccff_head, ccff_en, ccff_commit, chanx_left_in, chanx_right_in,
    output ccff_tail, cfg_done, cfg_err, chanx_left_out, chanx_right_out, ipin_out
`ifdef CB_CHAN_READBACK_EN
    , input rb_load
`endif
  );

endinterface

// File: rtl/cb_chan_param_ccff_ipin_mux.sv
// Binary-select pin mux; any select code at or above MUX_SIZE drives 0.
module cb_ipin_mux #(
  parameter int unsigned MUX_SIZE = 6,
  parameter int unsigned SEL_W    = 3
) (
  input  logic [MUX_SIZE-1:0] in,
  input  logic [SEL_W-1:0]    sel,
  output logic                out
);

  always_comb begin
    out = 1'b0;
    for (int unsigned k = 0; k < MUX_SIZE; k++) begin
      if (sel == SEL_W'(k)) out = in[k];
    end
  end

endmodule

// File: rtl/cb_chan_param_ccff.sv
// Parametrised X-channel connection block with double-buffered, shift-count-checked config.
// Define CB_CHAN_READBACK_EN to add rb_load (active config copied back into the shift chain).
module cb_chan_param_ccff
  import cb_chan_pkg::*;
#(
  parameter int unsigned CHAN_W       = 9,
  parameter int unsigned NUM_IPIN     = 11,
  parameter int unsigned MUX_SIZE     = 6,
  parameter int unsigned TRACK_STRIDE = 4
) (
  input logic                  prog_clk,
  input logic                  pReset,
  cb_chan_param_ccff_if.slave  bus
);

  localparam int unsigned SEL_W = sel_width(MUX_SIZE);
  localparam int unsigned TOTAL = NUM_IPIN * SEL_W;
  localparam int unsigned CNT_W = clog2(TOTAL + 2);

  localparam logic [SEL_W-1:0] DISC      = SEL_W'(disc_sel(SEL_W));
  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TOTAL + 1);

  logic [TOTAL-1:0]    shadow;
  logic [TOTAL-1:0]    active;
  logic [CNT_W-1:0]    cnt;
  logic                cfg_done;
  logic                cfg_err;
  cb_state_e           state;
  logic [NUM_IPIN-1:0] ipin;

  assign bus.chanx_right_out = bus.chanx_left_in;
  assign bus.chanx_left_out  = bus.chanx_right_in;
  assign bus.ccff_tail       = shadow[TOTAL-1];
  assign bus.cfg_done        = cfg_done;
  assign bus.cfg_err         = cfg_err;
  assign bus.ipin_out        = ipin;

  // Shifting and readback touch only the shadow; active changes solely on a clean commit.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      shadow   <= '0;
      active   <= {NUM_IPIN{DISC}};
      cnt      <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
      state    <= IDLE;
    end else if (bus.ccff_en) begin
      shadow <= {shadow[TOTAL-2:0], bus.ccff_head};
      state  <= LOAD;
      if (state == IDLE)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
      if (bus.ccff_commit) cfg_err <= 1'b1;
    end
`ifdef CB_CHAN_READBACK_EN
    else if (bus.rb_load) begin
      shadow <= active;
      cnt    <= '0;
      state  <= IDLE;
    end
`endif
    else if (bus.ccff_commit) begin
      if (cnt == CNT_TOTAL) begin
        active   <= shadow;
        cfg_done <= 1'b1;
      end else begin
        cfg_err  <= 1'b1;
      end
      cnt   <= '0;
      state <= IDLE;
    end
  end

  // Mux i pairs left/right track t_j = (i + j*TRACK_STRIDE) mod CHAN_W on inputs 2j/2j+1.
  for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
    logic [MUX_SIZE-1:0] mux_in;
    for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_pair
      localparam int unsigned T = (i + j * TRACK_STRIDE) % CHAN_W;
      assign mux_in[2*j]   = bus.chanx_left_in[T];
      assign mux_in[2*j+1] = bus.chanx_right_in[T];
    end
    cb_ipin_mux #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_mux (
      .in  (mux_in),
      .sel (active[i*SEL_W +: SEL_W]),
      .out (ipin[i])
    );
  end

endmodule

// File: tb/tb_cb_chan_param_ccff.sv
// Directed, table-driven bench for cb_chan_param_ccff at default parameters (SEL_W=3, TOTAL=33).
module tb_cb_chan_param_ccff;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  always #5 prog_clk = ~prog_clk;

  cb_chan_param_ccff_if #(.CHAN_W(9), .NUM_IPIN(11)) bus ();

  cb_chan_param_ccff #(
    .CHAN_W       (9),
    .NUM_IPIN     (11),
    .MUX_SIZE     (6),
    .TRACK_STRIDE (4)
  ) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (bus)
  );

  // Field layout {f10, ..., f0}, 3 bits each; first bit shifted = MSB of f10.
  localparam logic [32:0] CFG_A = {30'h3FFF_FFFF, 3'd2};
  localparam logic [32:0] CFG_C = {30'h3FFF_FFFF, 3'd1};
  localparam logic [32:0] CFG_B = {3'd0, 3'd5, 3'd2, 3'd7, 3'd6, 3'd1,
                                   3'd4, 3'd3, 3'd0, 3'd5, 3'd2};

  typedef struct {
    logic [8:0]  l;
    logic [8:0]  r;
    logic [10:0] ipin;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ccff_head      = 1'b0;
    bus.ccff_en        = 1'b0;
    bus.ccff_commit    = 1'b0;
    bus.chanx_left_in  = '0;
    bus.chanx_right_in = '0;
`ifdef CB_CHAN_READBACK_EN
    bus.rb_load        = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    pReset = 1'b0;
    tick();
    pReset = 1'b1;
    tick();
  endtask

  task automatic shift_bits(input logic [63:0] d, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      bus.ccff_en   = 1'b1;
      bus.ccff_head = d[k];
      tick();
    end
    bus.ccff_en   = 1'b0;
    bus.ccff_head = 1'b0;
  endtask

  task automatic commit();
    bus.ccff_commit = 1'b1;
    tick();
    bus.ccff_commit = 1'b0;
  endtask

  task automatic drive_all_ones();
    bus.chanx_left_in  = 9'h1FF;
    bus.chanx_right_in = 9'h1FF;
    #1;
  endtask

  initial begin
    // Hand-computed for CFG_B: ipin = {L1,R8,L3,0,0,R5,L3,R7,L2,R0,L4}.
    vecs[0] = '{l: 9'h000, r: 9'h000, ipin: 11'h000};
    vecs[1] = '{l: 9'h1FF, r: 9'h000, ipin: 11'h515};
    vecs[2] = '{l: 9'h000, r: 9'h1FF, ipin: 11'h22A};
    vecs[3] = '{l: 9'h1FF, r: 9'h1FF, ipin: 11'h73F};
    vecs[4] = '{l: 9'h010, r: 9'h000, ipin: 11'h001};
    vecs[5] = '{l: 9'h008, r: 9'h000, ipin: 11'h110};
    vecs[6] = '{l: 9'h000, r: 9'h100, ipin: 11'h200};
    vecs[7] = '{l: 9'h000, r: 9'h080, ipin: 11'h008};
    vecs[8] = '{l: 9'h002, r: 9'h021, ipin: 11'h422};
    vecs[9] = '{l: 9'h1EF, r: 9'h000, ipin: 11'h514};

    clear_inputs();
    pReset = 1'b0;
    #12;
    drive_all_ones();
    chk("reset_ipin", 64'(bus.ipin_out), 64'h0);
    chk("reset_done", 64'(bus.cfg_done), 64'h0);
    chk("reset_err",  64'(bus.cfg_err),  64'h0);
    chk("reset_tail", 64'(bus.ccff_tail), 64'h0);
    @(posedge prog_clk);
    #1;
    pReset = 1'b1;
    tick();

    // Reset asserted between edges mid-load clears the chain immediately.
    shift_bits(64'h1_FFFF_FFFF, 33);
    chk("load_tail_ones", 64'(bus.ccff_tail), 64'h1);
    #2;
    pReset = 1'b0;
    #1;
    drive_all_ones();
    chk("midload_tail", 64'(bus.ccff_tail), 64'h0);
    chk("midload_ipin", 64'(bus.ipin_out),  64'h0);
    chk("midload_done", 64'(bus.cfg_done),  64'h0);
    @(posedge prog_clk);
    #1;
    pReset = 1'b1;
    tick();
    commit();
    chk("postrst_commit_err",  64'(bus.cfg_err),  64'h1);
    chk("postrst_commit_done", 64'(bus.cfg_done), 64'h0);

    do_reset();
    shift_bits(64'(CFG_A[32:1]), 32);
    commit();
    drive_all_ones();
    chk("short_err",  64'(bus.cfg_err),  64'h1);
    chk("short_done", 64'(bus.cfg_done), 64'h0);
    chk("short_ipin", 64'(bus.ipin_out), 64'h0);

    do_reset();
    shift_bits({31'h0, CFG_A}, 34);
    commit();
    drive_all_ones();
    chk("long_err",  64'(bus.cfg_err),  64'h1);
    chk("long_done", 64'(bus.cfg_done), 64'h0);
    chk("long_ipin", 64'(bus.ipin_out), 64'h0);

    do_reset();
    shift_bits(64'(CFG_A[32:1]), 32);
    bus.ccff_en     = 1'b1;
    bus.ccff_commit = 1'b1;
    bus.ccff_head   = CFG_A[0];
    tick();
    clear_inputs();
    drive_all_ones();
    chk("simul_err",  64'(bus.cfg_err),   64'h1);
    chk("simul_done", 64'(bus.cfg_done),  64'h0);
    chk("simul_ipin", 64'(bus.ipin_out),  64'h0);
    chk("simul_tail", 64'(bus.ccff_tail), 64'(CFG_A[32]));

    // Basic route: field0 = 2 selects left[4].
    do_reset();
    shift_bits(64'(CFG_A), 33);
    drive_all_ones();
    chk("pre_commit_ipin", 64'(bus.ipin_out), 64'h0);
    bus.chanx_left_in  = 9'h010;
    bus.chanx_right_in = 9'h000;
    commit();
    chk("basic_ipin", 64'(bus.ipin_out), 64'h001);
    chk("basic_done", 64'(bus.cfg_done), 64'h1);
    chk("basic_err",  64'(bus.cfg_err),  64'h0);

    // Hitless reprogram: old route holds while CFG_C shifts in.
    for (int k = 32; k >= 0; k--) begin
      bus.ccff_en        = 1'b1;
      bus.ccff_head      = CFG_C[k];
      bus.chanx_left_in  = (k % 2 == 1) ? 9'h010 : 9'h000;
      bus.chanx_right_in = (k % 2 == 1) ? 9'h001 : 9'h1FE;
      #1;
      chk("hitless_hold", 64'(bus.ipin_out[0]), (k % 2 == 1) ? 64'h1 : 64'h0);
      if (k % 8 == 0) begin
        chk("hitless_pass_r", 64'(bus.chanx_right_out), 64'(bus.chanx_left_in));
        chk("hitless_pass_l", 64'(bus.chanx_left_out),  64'(bus.chanx_right_in));
      end
      tick();
    end
    bus.ccff_en        = 1'b0;
    bus.chanx_left_in  = 9'h010;
    bus.chanx_right_in = 9'h000;
    #1;
    chk("hitless_before_commit", 64'(bus.ipin_out[0]), 64'h1);
    commit();
    chk("hitless_after_commit", 64'(bus.ipin_out[0]), 64'h0);
    bus.chanx_right_in = 9'h001;
    #1;
    chk("hitless_right0", 64'(bus.ipin_out[0]), 64'h1);

    shift_bits(64'(CFG_B), 33);
    commit();
    chk("cfgb_err", 64'(bus.cfg_err), 64'h0);
    for (int v = 0; v < 10; v++) begin
      bus.chanx_left_in  = vecs[v].l;
      bus.chanx_right_in = vecs[v].r;
      #1;
      chk($sformatf("vec%0d_ipin", v), 64'(bus.ipin_out), 64'(vecs[v].ipin));
      chk($sformatf("vec%0d_rout", v), 64'(bus.chanx_right_out), 64'(vecs[v].l));
      chk($sformatf("vec%0d_lout", v), 64'(bus.chanx_left_out),  64'(vecs[v].r));
    end

    // Short load after a good config leaves the live routing untouched.
    shift_bits(64'h1F, 5);
    commit();
    drive_all_ones();
    chk("short2_err",  64'(bus.cfg_err),  64'h1);
    chk("short2_done", 64'(bus.cfg_done), 64'h1);
    chk("short2_ipin", 64'(bus.ipin_out), 64'h73F);

`ifdef CB_CHAN_READBACK_EN
    begin
      logic [32:0] got;
      got = '0;
      bus.rb_load = 1'b1;
      tick();
      bus.rb_load = 1'b0;
      for (int k = 32; k >= 0; k--) begin
        got[k]        = bus.ccff_tail;
        bus.ccff_en   = 1'b1;
        bus.ccff_head = 1'b0;
        tick();
      end
      bus.ccff_en = 1'b0;
      chk("readback_stream", 64'(got), 64'(CFG_B));
    end
    do_reset();
    bus.rb_load     = 1'b1;
    bus.ccff_commit = 1'b1;
    tick();
    clear_inputs();
    #1;
    chk("rb_commit_err",  64'(bus.cfg_err),   64'h0);
    chk("rb_commit_done", 64'(bus.cfg_done),  64'h0);
    chk("rb_commit_tail", 64'(bus.ccff_tail), 64'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
